// File: rtl/ifu_fetch_queue.sv
// Instruction fetch queue: issues sequential fetch requests under a credit limit and
// buffers in-order responses for the EXU. Define IFQ_BYPASS_EN for same-cycle response bypass.
module ifu_fetch_queue #(
    parameter int PC_SIZE    = 32,
    parameter int INSTR_SIZE = 32,
    parameter int DEPTH      = 4,
    parameter int OUTS       = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [PC_SIZE-1:0]    pc_rtvec,
    input  logic                  flush_valid,
    input  logic [PC_SIZE-1:0]    flush_pc,
    output logic                  ifu_req_valid,
    input  logic                  ifu_req_ready,
    output logic [PC_SIZE-1:0]    ifu_req_pc,
    input  logic                  ifu_rsp_valid,
    output logic                  ifu_rsp_ready,
    input  logic [INSTR_SIZE-1:0] ifu_rsp_instr,
    output logic                  o_valid,
    input  logic                  o_ready,
    output logic [INSTR_SIZE-1:0] o_ir,
    output logic [PC_SIZE-1:0]    o_pc
);
    localparam int QAW = $clog2(DEPTH);
    localparam int PAW = (OUTS > 1) ? $clog2(OUTS) : 1;
    localparam int CW  = $clog2(DEPTH + 1) + 1;

    logic                  boot_q, boot_d;
    logic [PC_SIZE-1:0]    fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]         in_flight_q, in_flight_d;
    logic [CW-1:0]         drop_cnt_q, drop_cnt_d;
    logic [CW-1:0]         count_q, count_d;
    logic [QAW-1:0]        q_wr_q, q_wr_d, q_rd_q, q_rd_d;
    logic [PAW-1:0]        p_wr_q, p_wr_d, p_rd_q, p_rd_d;
    logic [PC_SIZE-1:0]    q_pc_q [DEPTH];
    logic [INSTR_SIZE-1:0] q_ir_q [DEPTH];
    logic [PC_SIZE-1:0]    p_pc_q [OUTS];

    logic req_hs, rsp_hs, rsp_keep, byp, q_push, q_pop, q_nonempty;

    function automatic logic [PAW-1:0] p_inc(input logic [PAW-1:0] p);
        return (p == PAW'(OUTS - 1)) ? '0 : p + 1'b1;
    endfunction

    assign ifu_rsp_ready = 1'b1;
    assign ifu_req_pc    = fetch_pc_q;
    assign ifu_req_valid = !boot_q && (in_flight_q < CW'(OUTS))
                         && ((in_flight_q - drop_cnt_q + count_q) < CW'(DEPTH));
    assign req_hs     = ifu_req_valid && ifu_req_ready;
    // Responses with nothing in flight (e.g. abandoned by reset) are ignored.
    assign rsp_hs     = ifu_rsp_valid && (in_flight_q != '0);
    assign rsp_keep   = rsp_hs && (drop_cnt_q == '0) && !flush_valid;
    assign q_nonempty = (count_q != '0);

`ifdef IFQ_BYPASS_EN
    assign byp = rsp_keep && !q_nonempty;
`else
    assign byp = 1'b0;
`endif

    assign o_valid = q_nonempty || byp;
    assign o_ir    = q_nonempty ? q_ir_q[q_rd_q] : (byp ? ifu_rsp_instr : '0);
    assign o_pc    = q_nonempty ? q_pc_q[q_rd_q] : (byp ? p_pc_q[p_rd_q] : '0);
    assign q_push  = rsp_keep && !(byp && o_ready);
    assign q_pop   = q_nonempty && o_ready && !flush_valid;

    always_comb begin
        boot_d      = boot_q;
        fetch_pc_d  = fetch_pc_q;
        in_flight_d = in_flight_q + CW'(req_hs) - CW'(rsp_hs);
        drop_cnt_d  = drop_cnt_q;
        count_d     = count_q;
        q_wr_d      = q_wr_q;
        q_rd_d      = q_rd_q;
        p_wr_d      = p_wr_q;
        p_rd_d      = p_rd_q;
        if (boot_q) begin
            boot_d     = 1'b0;
            fetch_pc_d = pc_rtvec;
        end
        if (flush_valid) begin
            // Everything still in flight after this cycle becomes a response to drop.
            fetch_pc_d = flush_pc;
            drop_cnt_d = in_flight_d;
            count_d    = '0;
            q_wr_d     = '0;
            q_rd_d     = '0;
            p_wr_d     = '0;
            p_rd_d     = '0;
        end else begin
            if (req_hs) begin
                fetch_pc_d = fetch_pc_q + PC_SIZE'(4);
                p_wr_d     = p_inc(p_wr_q);
            end
            if (rsp_hs && (drop_cnt_q != '0))
                drop_cnt_d = drop_cnt_q - 1'b1;
            if (rsp_keep)
                p_rd_d = p_inc(p_rd_q);
            if (q_push)
                q_wr_d = q_wr_q + 1'b1;
            if (q_pop)
                q_rd_d = q_rd_q + 1'b1;
            count_d = count_q + CW'(q_push) - CW'(q_pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            boot_q      <= 1'b1;
            fetch_pc_q  <= '0;
            in_flight_q <= '0;
            drop_cnt_q  <= '0;
            count_q     <= '0;
            q_wr_q      <= '0;
            q_rd_q      <= '0;
            p_wr_q      <= '0;
            p_rd_q      <= '0;
        end else begin
            boot_q      <= boot_d;
            fetch_pc_q  <= fetch_pc_d;
            in_flight_q <= in_flight_d;
            drop_cnt_q  <= drop_cnt_d;
            count_q     <= count_d;
            q_wr_q      <= q_wr_d;
            q_rd_q      <= q_rd_d;
            p_wr_q      <= p_wr_d;
            p_rd_q      <= p_rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (req_hs && !flush_valid)
            p_pc_q[p_wr_q] <= fetch_pc_q;
        if (q_push) begin
            q_pc_q[q_wr_q] <= p_pc_q[p_rd_q];
            q_ir_q[q_wr_q] <= ifu_rsp_instr;
        end
    end
endmodule
